accum4_seq: RTL and testbench

4-bit signed accumulator sequencer that drives the team's 4-bit adder/subtracter (`adder_subtracter4`) with the accumulator as operand x and an incoming operand as y. It accepts one command per transaction over a valid/ready handshake and registers the result. It returns the result and its overflow flag over an output valid/ready handshake, and keeps a sticky overflow flag. It sits between the operand/command source and any consumer of arithmetic results.

---
 rtl/accum4_pkg.sv | 20 ++
 rtl/adder_subtracter4.sv | 17 +
 rtl/accum4_seq.sv | 106 ++++++++++
 tb/tb_accum4_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/accum4_pkg.sv
// rtl/accum4_pkg.sv - shared encodings and saturation limits for the 4-bit accumulator sequencer
package accum4_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic [3:0] SAT_MAX = 4'h7;
  localparam logic [3:0] SAT_MIN = 4'h8;

endpackage

// File: rtl/adder_subtracter4.sv
// rtl/adder_subtracter4.sv - combinational 4-bit two's complement adder/subtracter with signed overflow
module adder_subtracter4 (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic       i_c_in,
  output logic [3:0] o_sum,
  output logic       o_v
);

  logic [3:0] w_y_eff;

  // c_in doubles as the subtract select: x + ~y + 1 == x - y
  assign w_y_eff = i_y ^ {4{i_c_in}};
  assign o_sum   = i_x + w_y_eff + {3'b000, i_c_in};
  assign o_v     = (i_x[3] == w_y_eff[3]) && (o_sum[3] != i_x[3]);

endmodule

// File: rtl/accum4_seq.sv
// rtl/accum4_seq.sv - 4-bit signed accumulator sequencer with valid/ready command and result handshakes
// Optional saturation on ADD/SUB overflow when ACC4_SAT_EN is defined.
module accum4_seq
  import accum4_pkg::*;
#(
  parameter logic [3:0] ACC_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_acc,
  output logic       out_v,
  output logic       ovf_sticky
);

  state_t     r_state;
  state_t     w_next_state;
  op_t        r_op;
  logic [3:0] r_data;
  logic [3:0] r_acc;
  logic       r_v;
  logic       r_sticky;

  logic [3:0] w_sum;
  logic       w_ovf;
  logic [3:0] w_arith;

  adder_subtracter4 u_addsub (
    .i_x    (r_acc),
    .i_y    (r_data),
    .i_c_in (r_op == OP_SUB),
    .o_sum  (w_sum),
    .o_v    (w_ovf)
  );

`ifdef ACC4_SAT_EN
  // Clamp toward the sign the accumulator held before the operation.
  assign w_arith = w_ovf ? (r_acc[3] ? SAT_MIN : SAT_MAX) : w_sum;
`else
  assign w_arith = w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: if (out_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_LOAD;
      r_data   <= 4'h0;
      r_acc    <= ACC_RESET;
      r_v      <= 1'b0;
      r_sticky <= 1'b0;
    end else if (r_state == ST_IDLE && in_valid) begin
      r_op   <= op_t'(in_op);
      r_data <= in_data;
    end else if (r_state == ST_EXEC) begin
      case (r_op)
        OP_LOAD: begin
          r_acc <= r_data;
          r_v   <= 1'b0;
        end
        OP_ADD, OP_SUB: begin
          r_acc    <= w_arith;
          r_v      <= w_ovf;
          r_sticky <= r_sticky | w_ovf;
        end
        OP_CLR: begin
          r_acc    <= ACC_RESET;
          r_v      <= 1'b0;
          r_sticky <= 1'b0;
        end
        default: r_v <= 1'b0;
      endcase
    end
  end

  assign out_acc    = r_acc;
  assign out_v      = r_v;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_accum4_seq.sv
// tb/tb_accum4_seq.sv - directed self-checking bench for accum4_seq (expectations follow ACC4_SAT_EN)
module tb_accum4_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = 2'b00;
  logic [3:0] in_data = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_acc;
  logic       out_v;
  logic       ovf_sticky;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] C_LOAD = 2'b00;
  localparam logic [1:0] C_ADD  = 2'b01;
  localparam logic [1:0] C_SUB  = 2'b10;
  localparam logic [1:0] C_CLR  = 2'b11;

  accum4_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_v      (out_v),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  // Issues one command, scrambles in_op/in_data right after acceptance, and reports
  // the result seen once out_valid rises; completes the output handshake if asked.
  task automatic send(input logic [1:0] op, input logic [3:0] data, input bit complete,
                      output int lat, output logic [3:0] acc, output logic v,
                      output logic sticky);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = C_CLR;
    in_data  = ~data;
    lat = 0;
    while (lat < 8) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    acc    = out_acc;
    v      = out_v;
    sticky = ovf_sticky;
    if (complete) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_acc !== 4'h0) begin errors++; $display("FAIL reset_out_acc: got %h expected 0", out_acc); end
    checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v: got %b expected 0", out_v); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", ovf_sticky); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_load_add;
    int lat; logic [3:0] acc; logic v, s;
    send(C_LOAD, 4'h3, 1'b1, lat, acc, v, s);
    checks++; if (acc !== 4'h3 || lat !== 1) begin errors++; $display("FAIL load3: got acc=%h lat=%0d expected 3/1", acc, lat); end
    send(C_ADD, 4'h2, 1'b1, lat, acc, v, s);
    checks++; if (acc !== 4'h5 || v !== 1'b0) begin errors++; $display("FAIL add2: got acc=%h v=%b expected 5/0", acc, v); end
    checks++; if (lat !== 1 || s !== 1'b0) begin errors++; $display("FAIL add2_lat_sticky: got lat=%0d sticky=%b expected 1/0", lat, s); end
  endtask

  task automatic test_add_overflow;
    int lat; logic [3:0] acc; logic v, s;
    logic [3:0] exp_acc;
`ifdef ACC4_SAT_EN
    exp_acc = 4'h7;
`else
    exp_acc = 4'h8;
`endif
    send(C_LOAD, 4'h7, 1'b1, lat, acc, v, s);
    send(C_ADD, 4'h1, 1'b1, lat, acc, v, s);
    checks++; if (acc !== exp_acc || v !== 1'b1) begin errors++; $display("FAIL add_ovf: got acc=%h v=%b expected %h/1", acc, v, exp_acc); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL add_ovf_sticky: got %b expected 1", s); end
  endtask

  task automatic test_sub;
    int lat; logic [3:0] acc; logic v, s;
    logic [3:0] exp_acc;
`ifdef ACC4_SAT_EN
    exp_acc = 4'h8;
`else
    exp_acc = 4'h7;
`endif
    send(C_LOAD, 4'h0, 1'b1, lat, acc, v, s);
    send(C_SUB, 4'h1, 1'b1, lat, acc, v, s);
    checks++; if (acc !== 4'hF || v !== 1'b0) begin errors++; $display("FAIL sub_0_1: got acc=%h v=%b expected f/0", acc, v); end
    send(C_LOAD, 4'h8, 1'b1, lat, acc, v, s);
    send(C_SUB, 4'h1, 1'b1, lat, acc, v, s);
    checks++; if (acc !== exp_acc || v !== 1'b1) begin errors++; $display("FAIL sub_ovf: got acc=%h v=%b expected %h/1", acc, v, exp_acc); end
    send(C_CLR, 4'h5, 1'b1, lat, acc, v, s);
    checks++; if (acc !== 4'h0 || v !== 1'b0 || s !== 1'b0) begin errors++; $display("FAIL clr: got acc=%h v=%b sticky=%b expected 0/0/0", acc, v, s); end
  endtask

  task automatic test_backpressure;
    int lat; logic [3:0] acc; logic v, s;
    send(C_LOAD, 4'h5, 1'b0, lat, acc, v, s);
    checks++; if (acc !== 4'h5 || lat !== 1) begin errors++; $display("FAIL bp_load: got acc=%h lat=%0d expected 5/1", acc, lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = C_ADD;
      in_data  = 4'(i + 1);
      @(negedge clk);
      checks++;
      if (out_acc !== 4'h5 || out_v !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got acc=%h v=%b in_ready=%b out_valid=%b expected 5/0/0/1", i, out_acc, out_v, in_ready, out_valid);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== 4'h5) begin errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b acc=%h expected 1/0/5", in_ready, out_valid, out_acc); end
  endtask

  task automatic test_reset_mid_resp;
    int lat; logic [3:0] acc; logic v, s;
    send(C_LOAD, 4'h7, 1'b1, lat, acc, v, s);
    send(C_ADD, 4'h1, 1'b0, lat, acc, v, s);
    checks++; if (out_valid !== 1'b1 || ovf_sticky !== 1'b1) begin errors++; $display("FAIL pre_abort: got out_valid=%b sticky=%b expected 1/1", out_valid, ovf_sticky); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 4'h0 || out_v !== 1'b0 || ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: got out_valid=%b in_ready=%b acc=%h v=%b sticky=%b expected 0/1/0/0/0", out_valid, in_ready, out_acc, out_v, ovf_sticky);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(C_ADD, 4'h4, 1'b1, lat, acc, v, s);
    checks++; if (acc !== 4'h4 || v !== 1'b0 || s !== 1'b0 || lat !== 1) begin errors++; $display("FAIL post_abort_add: got acc=%h v=%b sticky=%b lat=%0d expected 4/0/0/1", acc, v, s, lat); end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_add_overflow();
    test_sub();
    test_backpressure();
    test_reset_mid_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
